// File: rtl/fp_divider.sv
// ---------------------------------------------------------------------------
// fp_divider -- sequential single-precision floating-point divider.
//
// Computes z = x / y with one restoring division step per clock. The operator
// holds x and y stable and keeps run high for the whole operation. stall stays
// high for 25 cycles after run rises, and then z is valid. Dropping run sends
// the block back to idle, and a later rise of run starts a fresh division.
// The mantissa is truncated. Exponent-0 operands count as zero. Underflow
// flushes to zero. Overflow and divide-by-zero saturate to a signed infinity
// pattern.
//
// Ports
//   clk    in   1   sole clock, rising edge
//   rst    in   1   synchronous active-high reset, overrides run
//   run    in   1   high for the whole operation, low = idle
//   x      in  32   dividend (IEEE-754 single layout)
//   y      in  32   divisor  (IEEE-754 single layout)
//   stall  out  1   high while the result is not yet valid
//   z      out 32   quotient, valid when run=1 and stall=0, else 0
// ---------------------------------------------------------------------------
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);

    localparam logic [4:0] LAST_STEP = 5'd25;

    logic [4:0]  s_q, s_d;
    logic [25:0] r_q, r_d;
    logic [24:0] q_q, q_d;
    logic [25:0] r_src;
    logic [25:0] diff;

    // ---------------- restoring division datapath ----------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave one unassigned and infer a latch.
        s_d = s_q;
        r_d = r_q;
        q_d = q_q;

        // Step 0 loads the dividend mantissa with its hidden one. Every later
        // step works on the remainder carried over from the previous step.
        r_src = (s_q == 5'd0) ? {3'b001, x[22:0]} : r_q;
        diff  = r_src - {3'b001, y[22:0]};

        if (!run) begin
            // R and Q need no clearing here. A restart runs 25 fresh steps
            // that reload R from x and shift every old bit out of Q.
            s_d = 5'd0;
        end else if (s_q != LAST_STEP) begin
            s_d = s_q + 5'd1;
            // diff[25] is the borrow. Operands stay below 2^25, so bit 25
            // works as the sign bit of the trial subtraction.
            if (!diff[25]) begin
                r_d = diff << 1;
                q_d = {q_q[23:0], 1'b1};
            end else begin
                r_d = r_src << 1;
                q_d = {q_q[23:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the edge.
        if (rst) begin
            // NOTE: the remainder and quotient registers are reset on purpose,
            // so a reset always leaves a known datapath.
            s_q <= 5'd0;
            r_q <= 26'd0;
            q_q <= 25'd0;
        end else begin
            s_q <= s_d;
            r_q <= r_d;
            q_q <= q_d;
        end
    end

    // ---------------- normalise, pack and select ----------------
    logic              sign;
    logic [7:0]        xe, ye;
    logic signed [9:0] e;
    logic [22:0]       mant;

    always_comb begin
        sign = x[31] ^ y[31];
        xe   = x[30:23];
        ye   = y[30:23];
        // The mantissa quotient lies in (0.5, 2). When Q[24] is 0 the leading
        // one sits one place lower, so the exponent loses one.
        e    = $signed({2'b00, xe}) - $signed({2'b00, ye})
             + (q_q[24] ? 10'sd127 : 10'sd126);
        mant = q_q[24] ? q_q[23:1] : q_q[22:0];

        if (!run || s_q != LAST_STEP) begin
            z = 32'd0;
        end else if (ye == 8'd0) begin
            z = {sign, 8'hFF, 23'd0};
        end else if (xe == 8'd0) begin
            z = 32'd0;
        end else if (e <= 10'sd0) begin
            z = 32'd0;
        end else if (e >= 10'sd255) begin
            z = {sign, 8'hFF, 23'd0};
        end else begin
            z = {sign, e[7:0], mant};
        end
    end

    assign stall = run & (s_q != LAST_STEP);

endmodule

// File: tb/tb_fp_divider.sv
// ---------------------------------------------------------------------------
// tb_fp_divider -- directed self-checking bench for fp_divider.
// Drives inputs #1 after a rising edge and samples outputs at that same point.
// All expected values are constants worked out by hand from IEEE-754 encodings.
// ---------------------------------------------------------------------------
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] x;
    logic [31:0] y;
    logic        stall;
    logic [31:0] z;

    int total = 0;
    int bad   = 0;

    localparam int MAX_WAIT = 60;

    fp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .x     (x),
        .y     (y),
        .stall (stall),
        .z     (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait, with a bounded budget, until stall falls. Returns the number of
    // edges counted after run rose.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (stall === 1'b1 && cycles < MAX_WAIT) begin
            tick();
            cycles++;
        end
    endtask

    // One full operation: raise run, check that z stays 0 while stalled, count
    // the stall cycles, check the result, then drop run for one cycle and
    // check the idle outputs.
    task automatic do_op(input string tag, input logic [31:0] xa,
                         input logic [31:0] ya, input logic [31:0] exp);
        int cycles;
        x   = xa;
        y   = ya;
        run = 1'b1;
        #1;
        check({tag, ".z_busy"}, z, 32'd0);
        wait_result(cycles);
        check({tag, ".stall_cycles"}, cycles, 32'd25);
        check({tag, ".z"}, z, exp);
        run = 1'b0;
        #1;
        check({tag, ".idle_stall"}, {31'd0, stall}, 32'd0);
        tick();
        check({tag, ".idle_z"}, z, 32'd0);
    endtask

    initial begin
        int cycles;
        rst = 1'b1;
        run = 1'b0;
        x   = 32'd0;
        y   = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset.stall", {31'd0, stall}, 32'd0);
        check("reset.z", z, 32'd0);

        do_op("div_6_2",    32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        do_op("div_1_3",    32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
        do_op("div_1_m3",   32'h3F80_0000, 32'hC040_0000, 32'hBEAA_AAAA);
        do_op("div_1_0",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
        do_op("div_m1_0",   32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000);
        do_op("div_0_0",    32'h0000_0000, 32'h0000_0000, 32'h7F80_0000);
        do_op("div_0_2",    32'h0000_0000, 32'h4000_0000, 32'h0000_0000);
        do_op("underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000);
        do_op("overflow",   32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000);
        do_op("div_3_m1p5", 32'h4040_0000, 32'hBFC0_0000, 32'hC000_0000);

        // Reset pulsed at S=10 with run held high. The full sequence restarts.
        x   = 32'h40C0_0000;
        y   = 32'h4000_0000;
        run = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.stall", {31'd0, stall}, 32'd1);
        wait_result(cycles);
        check("rst_mid.stall_cycles", cycles, 32'd25);
        check("rst_mid.z", z, 32'h4040_0000);
        run = 1'b0;
        tick();

        // Back-to-back runs with a one-cycle gap. The second result must not
        // depend on the first.
        do_op("b2b_first",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        do_op("b2b_second", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
